gate_sweep_checker: RTL and testbench

Self-checking truth-table sweeper for the gates family. It replaces hand-written per-gate benches with one synthesizable block, usable in simulation or on the board.
- Walks all 2^N_INPUTS input vectors of an external N-input gate under test.
- Holds each vector for SETTLE_CYCLES, then samples the gate's output.
- Compares each sample against an internal reference gate selected by mode.
- Reports pass/fail, mismatch count and the first failing vector.

---
 rtl/gate_sweep_checker_pkg.sv | 19 +
 rtl/gate_ref.sv | 28 ++
 rtl/gate_sweep_checker.sv | 129 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_checker_pkg.sv
// Shared gate-mode encodings and sweep FSM state type for the gates family checkers.
package gate_sweep_checker_pkg;

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_BUF  = 3'd6;
    localparam logic [2:0] MODE_NOT  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gate_ref.sv
// Combinational reference gate: reduction of vec selected by mode.
// With a single input the reductions collapse naturally to BUF/NOT.
module gate_ref
    import gate_sweep_checker_pkg::*;
#(
    parameter int N_INPUTS = 2
) (
    input  logic [2:0]          mode,
    input  logic [N_INPUTS-1:0] vec,
    output logic                y
);

    always_comb begin
        y = 1'b0;
        case (mode)
            MODE_AND:  y = &vec;
            MODE_OR:   y = |vec;
            MODE_NAND: y = ~&vec;
            MODE_NOR:  y = ~|vec;
            MODE_XOR:  y = ^vec;
            MODE_XNOR: y = ~^vec;
            MODE_BUF:  y = vec[0];
            MODE_NOT:  y = ~vec[0];
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Walks every input vector of an external gate, compares its settled output
// against gate_ref and reports pass, mismatch count and first failing vector.
//
// state   | meaning
// S_IDLE  | waiting for start; results of last sweep held
// S_DRIVE | vec_out driven, settle timer running, sample at terminal count
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module gate_sweep_checker
    import gate_sweep_checker_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          mode,
    input  logic                dut_out,
    output logic [N_INPUTS-1:0] vec_out,
    output logic                vec_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                first_fail_valid
);

    localparam int                  CW          = 8;
    localparam logic [CW-1:0]       SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] VEC_LAST    = '1;

    state_t              state_q, state_d;
    logic [2:0]          mode_q, mode_d;
    logic [N_INPUTS-1:0] vec_q, vec_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_INPUTS:0]   err_q, err_d;
    logic [N_INPUTS-1:0] ff_vec_q, ff_vec_d;
    logic                ff_valid_q, ff_valid_d;
    logic                pass_q, pass_d;
    logic                ref_y;

    gate_ref #(
        .N_INPUTS(N_INPUTS)
    ) u_gate_ref (
        .mode(mode_q),
        .vec (vec_q),
        .y   (ref_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            vec_q      <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            pass_q     <= pass_d;
        end
    end

    // Settle timer is a down-counter; the sample point is its terminal count.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        pass_d     = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    vec_d      = '0;
                    cnt_d      = SETTLE_LOAD;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    ff_valid_d = 1'b0;
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    if (dut_out != ref_y) begin
                        err_d = err_q + 1'b1;
                        if (!ff_valid_q) begin
                            ff_vec_d   = vec_q;
                            ff_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        pass_d  = (err_d == '0);
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = SETTLE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign vec_out          = vec_q;
    assign vec_valid        = (state_q == S_DRIVE);
    assign busy             = (state_q == S_DRIVE);
    assign done             = (state_q == S_DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three configurations (2x2, 3x1, 8x1) driven by a
// modelled gate-under-test with injectable faults, checked against a counting model.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[3];
    logic       start_s[3];
    logic [2:0] mode_s[3];
    logic       dout[3];
    logic [7:0] vo[3];
    logic [7:0] ffv[3];
    logic [8:0] errc[3];
    logic       vv[3], busy[3], done[3], pass[3], ffval[3];

    int           gut_mode[3];
    logic         stuck[3];
    logic [255:0] fault[3];

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] vo0, ffv0;
    logic [2:0] errc0, vo1, ffv1;
    logic [3:0] errc1;
    logic [7:0] vo2, ffv2;
    logic [8:0] errc2;

    gate_sweep_checker #(.N_INPUTS(2), .SETTLE_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start(start_s[0]), .mode(mode_s[0]), .dut_out(dout[0]),
        .vec_out(vo0), .vec_valid(vv[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc0), .first_fail_vec(ffv0), .first_fail_valid(ffval[0]));

    gate_sweep_checker #(.N_INPUTS(3), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start(start_s[1]), .mode(mode_s[1]), .dut_out(dout[1]),
        .vec_out(vo1), .vec_valid(vv[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc1), .first_fail_vec(ffv1), .first_fail_valid(ffval[1]));

    gate_sweep_checker #(.N_INPUTS(8), .SETTLE_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start(start_s[2]), .mode(mode_s[2]), .dut_out(dout[2]),
        .vec_out(vo2), .vec_valid(vv[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(errc2), .first_fail_vec(ffv2), .first_fail_valid(ffval[2]));

    assign vo[0]   = {6'd0, vo0};
    assign vo[1]   = {5'd0, vo1};
    assign vo[2]   = vo2;
    assign ffv[0]  = {6'd0, ffv0};
    assign ffv[1]  = {5'd0, ffv1};
    assign ffv[2]  = ffv2;
    assign errc[0] = {6'd0, errc0};
    assign errc[1] = {5'd0, errc1};
    assign errc[2] = errc2;

    function automatic int ni(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 8;
    endfunction

    function automatic int sc(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Gate truth from the count of ones among the first n bits.
    function automatic bit model_gate(input int m, input int n, input logic [7:0] v);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        case (m)
            0:       return ones == n;
            1:       return ones > 0;
            2:       return ones != n;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            6:       return v[0];
            default: return !v[0];
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            dout[k] = 1'b0;
            if (stuck[k]) dout[k] = 1'b1;
            else dout[k] = model_gate(gut_mode[k], ni(k), vo[k]) ^ fault[k][vo[k]];
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_sweep(input int k, input int md, input bit poke);
        int  n, s, len, cyc, seen, badseq, exp_err, exp_ff;
        bit  exp_ffv, want, have;
        n = ni(k);
        s = sc(k);
        len = (1 << n) * s + 1;
        exp_err = 0;
        exp_ff = 0;
        exp_ffv = 1'b0;
        for (int v = 0; v < (1 << n); v++) begin
            want = model_gate(md, n, 8'(v));
            have = stuck[k] ? 1'b1 : (model_gate(gut_mode[k], n, 8'(v)) ^ fault[k][v]);
            if (want != have) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ff = v;
                end
            end
        end
        @(negedge clk);
        check_eq("done_idle", done[k], 0);
        start_s[k] = 1'b1;
        mode_s[k] = 3'(md);
        @(negedge clk);
        start_s[k] = 1'b0;
        cyc = 1;
        seen = 0;
        badseq = 0;
        check_eq("valid_after_start", vv[k], 1);
        while (!done[k] && cyc < len + 5) begin
            if (vv[k]) begin
                if (int'(vo[k]) != seen / s) badseq++;
                if (!busy[k]) badseq++;
                seen++;
            end
            if (poke && cyc == 3) begin
                start_s[k] = 1'b1;
                mode_s[k] = 3'd4;
            end
            if (poke && cyc == 4) begin
                start_s[k] = 1'b0;
                mode_s[k] = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            cyc++;
        end
        start_s[k] = 1'b0;
        check_eq("latency", cyc, len);
        check_eq("vec_seq_bad", badseq, 0);
        check_eq("vec_cnt", seen, len - 1);
        check_eq("valid_in_done", vv[k], 0);
        check_eq("err_count", errc[k], exp_err);
        check_eq("pass", pass[k], (exp_err == 0) ? 1 : 0);
        check_eq("ff_valid", ffval[k], exp_ffv);
        if (exp_ffv) check_eq("ff_vec", ffv[k], exp_ff);
        check_eq("vec_hold", vo[k], (1 << n) - 1);
    endtask

    task automatic reset_mid_sweep();
        int cyc, ndone;
        @(negedge clk);
        start_s[0] = 1'b1;
        mode_s[0] = 3'd3;
        @(negedge clk);
        start_s[0] = 1'b0;
        cyc = 0;
        while (!(vv[0] && vo[0] == 8'd2) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_vec2", vo[0], 2);
        rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_vec_out", vo[0], 0);
        check_eq("rst_flags", {vv[0], busy[0], done[0], pass[0], ffval[0]}, 0);
        check_eq("rst_err_count", errc[0], 0);
        check_eq("rst_ff_vec", ffv[0], 0);
        rst[0] = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        check_eq("no_done_after_rst", ndone, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            start_s[k] = 1'b0;
            mode_s[k] = 3'd0;
            stuck[k] = 1'b0;
            fault[k] = '0;
            gut_mode[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq("reset_flags", {vv[k], busy[k], done[k], pass[k], ffval[k]}, 0);
            check_eq("reset_vals", {vo[k], errc[k], ffv[k]}, 0);
            rst[k] = 1'b0;
        end

        gut_mode[0] = 3;
        run_sweep(0, 3, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("pass_held", pass[0], 1);

        fault[0][0] = 1'b1;
        run_sweep(0, 3, 1'b0);

        reset_mid_sweep();
        fault[0] = '0;
        run_sweep(0, 3, 1'b0);

        run_sweep(0, 3, 1'b1);
        run_sweep(0, 3, 1'b0);

        gut_mode[1] = 0;
        stuck[1] = 1'b1;
        run_sweep(1, 0, 1'b0);
        stuck[1] = 1'b0;
        fault[1] = '0;
        fault[1][7] = 1'b1;
        run_sweep(1, 0, 1'b0);

        gut_mode[2] = 4;
        run_sweep(2, 4, 1'b0);

        repeat (24) begin
            int k, md;
            k = $urandom_range(0, 2);
            md = $urandom_range(0, 7);
            gut_mode[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : md;
            stuck[k] = ($urandom_range(0, 7) == 0);
            fault[k] = '0;
            if ($urandom_range(0, 1) == 1)
                for (int v = 0; v < 256; v++) fault[k][v] = ($urandom_range(0, 5) == 0);
            run_sweep(k, md, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
